// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for an 8-digit BCD stopwatch. It debounces the three
//   push-buttons into single press events and runs the IDLE/RUN/PAUSE/LAP
//   state machine. It derives the counter's count-enable and clear pulses
//   from a prescaler, and picks live or frozen (lap) data for the display.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   btn_start    raw start/stop button (async, active-high)
//   btn_lap      raw lap button        (async, active-high)
//   btn_clear    raw clear button      (async, active-high)
//   cnt_q[31:0]  packed BCD value from the counter (digit0 in [3:0])
//   cnt_enable   one-cycle count pulse to the counter
//   cnt_clear    one-cycle synchronous clear pulse to the counter
//   disp_data    registered value for the 7-segment decoder
//   state[1:0]   00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//   full         sticky flag: counter reached 99999999
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [31:0] cnt_q,
    output logic        cnt_enable,
    output logic        cnt_clear,
    output logic [31:0] disp_data,
    output logic [1:0]  state,
    output logic        full
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [31:0]   CNT_MAX    = 32'h9999_9999;

    localparam int B_START = 0;
    localparam int B_LAP   = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [0:2];

    state_t        st;
    logic [PW-1:0] presc;
    logic          freeze;
    logic [31:0]   snapshot;

    logic do_clear;
    logic do_start;
    logic do_lap;
    logic tick_pt;
    logic at_max;

    assign btn_raw = {btn_clear, btn_lap, btn_start};
    assign state   = st;

    // Button path: 2-FF synchronizer, then a stability counter. The debounced
    // level only follows sync2 after it has differed for DEB_CYCLES
    // consecutive cycles; a press pulse is emitted only on the 0->1 update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Coincident presses resolve as clear > start > lap; losers are dropped.
    assign do_clear = press[B_CLEAR];
    assign do_start = press[B_START] & ~press[B_CLEAR];
    assign do_lap   = press[B_LAP] & ~press[B_START] & ~press[B_CLEAR];

    assign tick_pt = (presc == PRESC_LAST);
    assign at_max  = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            presc      <= '0;
            cnt_enable <= 1'b0;
            cnt_clear  <= 1'b0;
            full       <= 1'b0;
            freeze     <= 1'b0;
            snapshot   <= '0;
            disp_data  <= '0;
        end else begin
            cnt_enable <= 1'b0;
            cnt_clear  <= 1'b0;
            disp_data  <= freeze ? snapshot : cnt_q;
            case (st)
                IDLE: begin
                    presc <= '0;
                    if (do_clear) begin
                        cnt_clear <= 1'b1;
                        full      <= 1'b0;
                        snapshot  <= '0;
                        freeze    <= 1'b0;
                    end else if (do_start) begin
                        st <= RUN;
                    end
                end
                RUN, LAP: begin
                    presc <= tick_pt ? '0 : presc + PW'(1);
                    // A tick at 99999999 is swallowed: the counter never
                    // wraps, the watch parks in PAUSE showing live data.
                    if (tick_pt && at_max) begin
                        full   <= 1'b1;
                        freeze <= 1'b0;
                        st     <= PAUSE;
                    end else begin
                        cnt_enable <= tick_pt;
                        if (do_start) begin
                            st <= PAUSE;
                        end else if (do_lap) begin
                            if (st == RUN) begin
                                st       <= LAP;
                                snapshot <= cnt_q;
                                freeze   <= 1'b1;
                            end else begin
                                st     <= RUN;
                                freeze <= 1'b0;
                            end
                        end
                    end
                end
                PAUSE: begin
                    // Prescaler holds here so a resumed run keeps its partial tick.
                    if (do_clear) begin
                        st        <= IDLE;
                        cnt_clear <= 1'b1;
                        presc     <= '0;
                        full      <= 1'b0;
                        snapshot  <= '0;
                        freeze    <= 1'b0;
                    end else if (do_start && !full) begin
                        st     <= RUN;
                        freeze <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3 and a behavioural
//   BCD counter driving cnt_q. Expected state/full changes and cnt_clear
//   pulses are queued by the stimulus; a negedge monitor pops and compares
//   each one as the DUT shows it. Point checks are queued to the same
//   monitor, which owns the pass/fail counters.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;
    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;
    localparam int K_CLR  = 0;
    localparam int K_ST   = 1;
    localparam int K_FULL = 2;

    logic        clk;
    logic        reset_n;
    logic        btn_start;
    logic        btn_lap;
    logic        btn_clear;
    logic [31:0] cnt_q;
    logic        cnt_enable;
    logic        cnt_clear;
    logic [31:0] disp_data;
    logic [1:0]  state;
    logic        full;

    logic        load_req;
    logic [31:0] load_val;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int          ev_kind [$];
    logic [31:0] ev_val  [$];
    string       dq_name [$];
    logic [31:0] dq_act  [$];
    logic [31:0] dq_exp  [$];

    int          chg_at;
    int          en_at;
    int          clr_at;
    logic [31:0] snap;

    logic [1:0]  prev_state;
    logic        prev_full;
    string       m_name;
    logic [31:0] m_act;
    logic [31:0] m_exp;
    int          m_kind;
    logic [31:0] m_val;

    stopwatch_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .cnt_q      (cnt_q),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .disp_data  (disp_data),
        .state      (state),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 8; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Behavioural 8-digit BCD counter
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cnt_q <= '0;
        else if (cnt_clear)  cnt_q <= '0;
        else if (load_req)   cnt_q <= load_val;
        else if (cnt_enable) cnt_q <= bcd_inc(cnt_q);
    end

    task automatic push_ev(input int kind, input logic [31:0] val);
        ev_kind.push_back(kind);
        ev_val.push_back(val);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dq_name.push_back(nm);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    task automatic observe(input int kind, input logic [31:0] val);
        checks++;
        if (ev_kind.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d val=%0h (nothing expected)", kind, val);
        end else begin
            m_kind = ev_kind.pop_front();
            m_val  = ev_val.pop_front();
            if (m_kind != kind || m_val !== val) begin
                errors++;
                $display("FAIL event @%0t: got kind=%0d val=%0h, expected kind=%0d val=%0h",
                         $time, kind, val, m_kind, m_val);
            end
        end
    endtask

    // Monitor: drains point checks and compares observed output events.
    always @(negedge clk) begin
        while (dq_name.size() > 0) begin
            m_name = dq_name.pop_front();
            m_act  = dq_act.pop_front();
            m_exp  = dq_exp.pop_front();
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", m_name, m_act, m_exp);
            end
        end
        if (mon_en) begin
            if (cnt_clear)           observe(K_CLR, 32'd1);
            if (state != prev_state) observe(K_ST, 32'(state));
            if (full != prev_full)   observe(K_FULL, 32'(full));
        end
        prev_state = state;
        prev_full  = full;
    end

    // Drive buttons from a negedge; record when state/enable/clear first react.
    task automatic do_press(input logic [2:0] mask, input int hold);
        logic [1:0]  s0;
        logic [31:0] cq_prev;
        s0     = state;
        chg_at = 0;
        en_at  = 0;
        clr_at = 0;
        snap   = '0;
        {btn_clear, btn_lap, btn_start} = mask;
        for (int n = 1; n <= hold + 8; n++) begin
            cq_prev = cnt_q;
            @(negedge clk);
            if (n == 1) load_req = 1'b0;
            if (n == hold) {btn_clear, btn_lap, btn_start} = 3'b000;
            if (chg_at == 0 && state != s0) begin
                chg_at = n;
                snap   = cq_prev;
            end
            if (en_at == 0 && cnt_enable) en_at = n;
            if (clr_at == 0 && cnt_clear) clr_at = n;
        end
    endtask

    task automatic wait_enable(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cnt_enable) begin
                n = i;
                break;
            end
        end
        chk("enable_seen", 32'(cnt_enable), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] cp;
        logic [31:0] snapv;
        bit          saw;

        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
        load_req  = 1'b0;
        load_val  = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enable", 32'(cnt_enable), 32'd0);
        chk("rst_clear", 32'(cnt_clear), 32'd0);
        chk("rst_disp", disp_data, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Short glitches must not register
        do_press(3'b001, 2);
        do_press(3'b100, 2);
        chk("glitch_state", 32'(state), 32'd0);
        chk("glitch_cnt", cnt_q, 32'd0);

        // Clear in IDLE pulses cnt_clear only; lap in IDLE ignored
        push_ev(K_CLR, 32'd1);
        do_press(3'b100, 4);
        chk("idle_clr_at", 32'(clr_at), 32'd6);
        chk("idle_clr_state", 32'(state), 32'd0);
        do_press(3'b010, 4);
        chk("idle_lap_state", 32'(state), 32'd0);

        // Start held 10 cycles: one press, RUN after 6 edges, tick every 4
        push_ev(K_ST, 32'd1);
        do_press(3'b001, 10);
        chk("start_latency", 32'(chg_at), 32'd6);
        chk("cnt_after_start", cnt_q, 32'd2);
        wait_enable(n);
        chk("tick_period", 32'(n), 32'd4);
        chk("cnt_after_tick", cnt_q, 32'd3);

        // Lap at cnt_q=5: display freezes while counting continues
        load_val = 32'd4;
        load_req = 1'b1;
        push_ev(K_ST, 32'd3);
        do_press(3'b010, 4);
        chk("lap_latency", 32'(chg_at), 32'd6);
        chk("lap_frozen_a", disp_data, 32'd5);
        repeat (5) @(negedge clk);
        chk("lap_cnt", cnt_q, 32'd8);
        chk("lap_frozen_b", disp_data, 32'd5);
        push_ev(K_ST, 32'd1);
        do_press(3'b010, 4);
        chk("unlap_latency", 32'(chg_at), 32'd6);
        for (int i = 0; i < 8; i++) begin
            cp = cnt_q;
            @(negedge clk);
            chk("disp_live", disp_data, cp);
        end

        // LAP -> PAUSE keeps the snapshot, PAUSE -> RUN returns to live
        push_ev(K_ST, 32'd3);
        do_press(3'b010, 4);
        snapv = snap;
        push_ev(K_ST, 32'd2);
        do_press(3'b001, 4);
        chk("lap_pause_disp", disp_data, snapv);
        push_ev(K_ST, 32'd1);
        do_press(3'b001, 4);
        cp = cnt_q;
        @(negedge clk);
        chk("resume_live", disp_data, cp);

        // Pause with prescaler at 2; resume ticks one cycle after RUN
        wait_enable(n);
        @(negedge clk);
        push_ev(K_ST, 32'd2);
        do_press(3'b001, 4);
        chk("pause_latency", 32'(chg_at), 32'd6);
        cp = cnt_q;
        repeat (8) @(negedge clk);
        chk("pause_hold", cnt_q, cp);
        push_ev(K_ST, 32'd1);
        do_press(3'b001, 4);
        chk("resume_latency", 32'(chg_at), 32'd6);
        chk("resume_first_tick", 32'(en_at), 32'd7);

        // Overflow at 99999999
        wait_enable(n);
        load_val = 32'h9999_9999;
        load_req = 1'b1;
        push_ev(K_ST, 32'd2);
        push_ev(K_FULL, 32'd1);
        saw = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) load_req = 1'b0;
            if (cnt_enable) saw = 1'b1;
        end
        chk("ovf_no_enable", 32'(saw), 32'd0);
        chk("ovf_state", 32'(state), 32'd2);
        chk("ovf_full", 32'(full), 32'd1);
        do_press(3'b001, 4);
        chk("full_start_ignored", 32'(state), 32'd2);
        chk("full_cnt_held", cnt_q, 32'h9999_9999);
        push_ev(K_CLR, 32'd1);
        push_ev(K_ST, 32'd0);
        push_ev(K_FULL, 32'd0);
        do_press(3'b100, 4);
        chk("ovf_clr_at", 32'(clr_at), 32'd6);
        chk("ovf_cleared_cnt", cnt_q, 32'd0);
        chk("ovf_cleared_full", 32'(full), 32'd0);

        // Start+clear together in PAUSE: clear wins
        push_ev(K_ST, 32'd1);
        do_press(3'b001, 4);
        push_ev(K_ST, 32'd2);
        do_press(3'b001, 4);
        push_ev(K_CLR, 32'd1);
        push_ev(K_ST, 32'd0);
        do_press(3'b101, 4);
        chk("prio_state", 32'(state), 32'd0);
        chk("prio_cnt", cnt_q, 32'd0);

        // Clear in RUN ignored
        push_ev(K_ST, 32'd1);
        do_press(3'b001, 4);
        do_press(3'b100, 4);
        chk("run_clear_ignored", 32'(state), 32'd1);
        chk("run_clear_no_pulse", 32'(clr_at), 32'd0);
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-run
        push_ev(K_ST, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_enable", 32'(cnt_enable), 32'd0);
        chk("arst_clear", 32'(cnt_clear), 32'd0);
        chk("arst_disp", disp_data, 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cnt_enable || cnt_clear) saw = 1'b1;
        end
        chk("post_rst_no_pulse", 32'(saw), 32'd0);
        chk("post_rst_state", 32'(state), 32'd0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(ev_kind.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
